// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit CPU front end.
package cpu_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HI   = 3'd1,
        S_LO   = 3'd2,
        S_CAP  = 3'd3,
        S_FULL = 3'd4
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetched instructions; pointers carry one extra bit so full and empty differ.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  fetch_entry_t       data,
    input  logic               pop,
    input  logic               flush,
    output logic [PTR_W:0]     count,
    output fetch_entry_t       head
);

    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    fetch_entry_t   slots [DEPTH];
    logic           do_push;
    logic           do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !flush;
    assign do_pop  = pop && (count != '0) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: an empty FIFO presents zeros at the head.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr[PTR_W-1:0]] <= data;
    end

    assign head = (count != '0) ? slots[rd_ptr[PTR_W-1:0]] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: two byte reads per 16-bit instruction, queued in a prefetch FIFO.
// Consumer handshake: a head transfers on any cycle where instr_valid && instr_ready.
module fetch_unit #(
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_cs,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [2:0]        fsm_state
);

    import cpu_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [7:0]        hi_q, hi_d;
    logic              push, pop;
    logic [CNT_W-1:0]  count, post_count;
    fetch_entry_t      push_entry, head;

    assign pop         = instr_valid && instr_ready;
    assign post_count  = count + CNT_W'(1) - CNT_W'(pop);
    assign push_entry  = '{pc: fpc_q, instr: {hi_q, mem_rdata}};

    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        hi_d     = hi_q;
        mem_cs   = 1'b0;
        mem_addr = fpc_q;
        push     = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_HI;
            S_HI: begin
                mem_cs  = 1'b1;
                state_d = S_LO;
            end
            S_LO: begin
                mem_cs   = 1'b1;
                mem_addr = fpc_q + ADDR_W'(1);
                hi_d     = mem_rdata;
                state_d  = S_CAP;
            end
            S_CAP: begin
                push    = 1'b1;
                fpc_d   = fpc_q + ADDR_W'(2);
                state_d = (post_count < DEPTH_C) ? S_HI : S_FULL;
            end
            S_FULL: begin
                if (count < DEPTH_C) state_d = S_HI;
            end
            default: state_d = S_IDLE;
        endcase
        // Redirect drops any half-assembled instruction and wins over every state.
        if (redirect) begin
            push    = 1'b0;
            fpc_d   = redirect_pc;
            state_d = S_HI;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            fpc_q   <= RESET_PC;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            hi_q    <= hi_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .data  (push_entry),
        .pop   (pop),
        .flush (redirect),
        .count (count),
        .head  (head)
    );

    assign instr_valid = (count != '0);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign mem_we      = 1'b0;
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle-by-cycle checks against hand-computed values.
module tb_fetch_unit;

    import cpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_addr;
    logic        mem_cs;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [2:0]  fsm_state;

    logic [7:0]  mem [0:65535];
    int          n_cmp = 0;
    int          n_err = 0;

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_addr    (mem_addr),
        .mem_cs      (mem_cs),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fsm_state   (fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte memory: data returned the cycle after its address cycle.
    always @(posedge clk) begin
        if (mem_cs) mem_rdata <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cs"},    32'(mem_cs),      32'd0);
        chk({tag, "_we"},    32'(mem_we),      32'd0);
        chk({tag, "_addr"},  32'(mem_addr),    32'h0000);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_instr"}, 32'(instr),       32'h0000);
        chk({tag, "_pc"},    32'(instr_pc),    32'h0000);
        chk({tag, "_st"},    32'(fsm_state),   32'(S_IDLE));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = 8'h12; mem[16'h0001] = 8'h34;
        mem[16'h0002] = 8'hAB; mem[16'h0003] = 8'hCD;
        mem[16'h0004] = 8'h56; mem[16'h0005] = 8'h78;
        mem[16'h0006] = 8'h9A; mem[16'h0007] = 8'hBC;
        mem[16'h0101] = 8'h11; mem[16'h0102] = 8'h22;
        mem[16'h0200] = 8'h33; mem[16'h0201] = 8'h44;
        mem[16'h0202] = 8'h55; mem[16'h0203] = 8'h66;

        rst_n       = 1'b1;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        #1 rst_n = 1'b0;
        #2 chk_reset("rst");
        tick(); tick();
        chk("rst_hold_st", 32'(fsm_state), 32'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // Fetch from reset with backpressure until the FIFO fills.
        tick();
        chk("e1_st",   32'(fsm_state), 32'(S_HI));
        chk("e1_cs",   32'(mem_cs),    32'd1);
        chk("e1_addr", 32'(mem_addr),  32'h0000);
        chk("e1_vld",  32'(instr_valid), 32'd0);
        tick();
        chk("e2_st",   32'(fsm_state), 32'(S_LO));
        chk("e2_addr", 32'(mem_addr),  32'h0001);
        tick();
        chk("e3_st",   32'(fsm_state), 32'(S_CAP));
        chk("e3_cs",   32'(mem_cs),    32'd0);
        chk("e3_vld",  32'(instr_valid), 32'd0);
        tick();
        chk("e4_vld",   32'(instr_valid), 32'd1);
        chk("e4_instr", 32'(instr),       32'h1234);
        chk("e4_pc",    32'(instr_pc),    32'h0000);
        chk("e4_addr",  32'(mem_addr),    32'h0002);
        tick(); tick();
        tick();
        chk("full_st",    32'(fsm_state), 32'(S_FULL));
        chk("full_cs",    32'(mem_cs),    32'd0);
        chk("full_instr", 32'(instr),     32'h1234);
        chk("full_pc",    32'(instr_pc),  32'h0000);
        tick();
        chk("hold_st",    32'(fsm_state), 32'(S_FULL));
        chk("hold_cs",    32'(mem_cs),    32'd0);
        chk("hold_instr", 32'(instr),     32'h1234);

        // Release backpressure: drain in order, then fetch resumes at 4.
        instr_ready = 1'b1;
        tick();
        chk("pop2_instr", 32'(instr),     32'hABCD);
        chk("pop2_pc",    32'(instr_pc),  32'h0002);
        chk("pop2_st",    32'(fsm_state), 32'(S_FULL));
        tick();
        chk("resume_st",   32'(fsm_state), 32'(S_HI));
        chk("resume_addr", 32'(mem_addr),  32'h0004);
        chk("resume_cs",   32'(mem_cs),    32'd1);
        chk("resume_vld",  32'(instr_valid), 32'd0);
        tick(); tick(); tick();
        chk("i3_instr", 32'(instr),    32'h5678);
        chk("i3_pc",    32'(instr_pc), 32'h0004);
        chk("i3_addr",  32'(mem_addr), 32'h0006);

        // Push and pop together in S_CAP with one entry queued.
        instr_ready = 1'b0;
        tick(); tick();
        chk("pp_st",    32'(fsm_state), 32'(S_CAP));
        chk("pp_pre",   32'(instr),     32'h5678);
        instr_ready = 1'b1;
        tick();
        chk("pp_vld",   32'(instr_valid), 32'd1);
        chk("pp_instr", 32'(instr),       32'h9ABC);
        chk("pp_pc",    32'(instr_pc),    32'h0006);
        chk("pp_st2",   32'(fsm_state),   32'(S_HI));
        tick();
        chk("pp_one",   32'(instr_valid), 32'd0);
        chk("pp_lo",    32'(fsm_state),   32'(S_LO));

        // Redirect during S_LO.
        redirect    = 1'b1;
        redirect_pc = 16'h0101;
        tick();
        redirect = 1'b0;
        chk("rd_vld",  32'(instr_valid), 32'd0);
        chk("rd_addr", 32'(mem_addr),    32'h0101);
        chk("rd_cs",   32'(mem_cs),      32'd1);
        tick();
        chk("rd_addr2", 32'(mem_addr),   32'h0102);
        tick();
        chk("rd_nostale", 32'(instr_valid), 32'd0);
        tick();
        chk("rd_instr", 32'(instr),      32'h1122);
        chk("rd_pc",    32'(instr_pc),   32'h0101);
        chk("rd_next",  32'(mem_addr),   32'h0103);
        tick();
        chk("rd_pop",   32'(instr_valid), 32'd0);

        // Wrap through the top of the address space.
        mem[16'hFFFF] = 8'hAB;
        mem[16'h0000] = 8'hCD;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        chk("wr_addr", 32'(mem_addr), 32'hFFFF);
        tick();
        chk("wr_addr2", 32'(mem_addr), 32'h0000);
        tick(); tick();
        chk("wr_instr", 32'(instr),    32'hABCD);
        chk("wr_pc",    32'(instr_pc), 32'hFFFF);
        chk("wr_next",  32'(mem_addr), 32'h0001);

        // Redirect in the same cycle as a pop.
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        tick();
        redirect = 1'b0;
        chk("rp_vld",   32'(instr_valid), 32'd0);
        chk("rp_instr", 32'(instr),       32'h0000);
        chk("rp_addr",  32'(mem_addr),    32'h0200);
        tick(); tick(); tick();
        chk("rp_new",   32'(instr),       32'h3344);
        chk("rp_pc",    32'(instr_pc),    32'h0200);
        instr_ready = 1'b0;
        tick(); tick(); tick();
        chk("rf_st",    32'(fsm_state),   32'(S_FULL));
        chk("rf_instr", 32'(instr),       32'h3344);

        // Asynchronous reset with a full FIFO, between clock edges.
        #1 rst_n = 1'b0;
        #1 chk_reset("midrst");
        mem[16'h0000] = 8'h12;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("re_st",   32'(fsm_state), 32'(S_HI));
        chk("re_addr", 32'(mem_addr),  32'h0000);
        tick(); tick(); tick();
        chk("re_instr", 32'(instr),    32'h1234);
        chk("re_pc",    32'(instr_pc), 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 8-bit CPU. Reads 16-bit instructions from the byte-wide `memory` block as two single-byte reads: high byte at `pc`, then low byte at `pc+1`. Each assembled instruction and its PC go into a small prefetch FIFO. The FIFO feeds the decoder/ALU stage through a valid/ready handshake, and a redirect input flushes the FIFO and restarts fetch at a new address.

## Interface

Parameters:
- `ADDR_W`, 16: memory address width.
- `RESET_PC`, 16'h0000: first fetch address after reset.
- `DEPTH`, 2: prefetch FIFO entries (power of 2, ≥2).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `mem_addr`, out, ADDR_W: byte address to memory.
- `mem_cs`, out, 1: memory chip select; high only in read cycles.
- `mem_we`, out, 1: memory write enable; tied 0.
- `mem_rdata`, in, 8: byte returned by memory, valid the cycle after its address cycle.
- `instr_valid`, out, 1: FIFO head holds an instruction.
- `instr_ready`, in, 1: consumer accepts the head this cycle.
- `instr`, out, 16: FIFO head instruction, `{hi, lo}`.
- `instr_pc`, out, ADDR_W: address of the head instruction's high byte.
- `redirect`, in, 1: flush and restart fetch.
- `redirect_pc`, in, ADDR_W: new fetch address; any alignment allowed.

## Operation

- The FSM has five states: `S_IDLE`, `S_HI`, `S_LO`, `S_CAP`, `S_FULL`.
- `S_IDLE` is the reset state. `mem_cs`=0. Next state is `S_HI`.
- `S_HI`: `mem_cs`=1, `mem_addr`=`fpc`. Next state is `S_LO`.
- `S_LO`: `mem_cs`=1, `mem_addr`=`fpc+1`; `hi_q` <= `mem_rdata`. Next state is `S_CAP`.
- `S_CAP`: `mem_cs`=0; push `{hi_q, mem_rdata}` with `fpc`; `fpc` <= `fpc+2`.
  - Next state is `S_HI` if the post-cycle count < `DEPTH`, else `S_FULL`.
- `S_FULL`: `mem_cs`=0. Next state is `S_HI` once the registered count < `DEPTH`.
- Push-space guarantee: `S_HI` is entered only when the count < `DEPTH`, and pops only lower the count, so the push in `S_CAP` never overflows.
- Pop: a pop occurs when `instr_valid && instr_ready`.
  - Push and pop in the same cycle leave the count unchanged; FIFO order is preserved.
- `instr_valid` = (count != 0). `instr` and `instr_pc` are the head entry, or 0 when empty.
- Redirect has the highest priority, in any state:
  - count <= 0; in-flight bytes are discarded with no push that cycle; `fpc` <= `redirect_pc`; next state is `S_HI`.
  - A pop in the redirect cycle still completes, i.e. the consumer has taken that head.
- Address arithmetic is modulo 2^ADDR_W: `16'hFFFF`+1 = `16'h0000`.
- `mem_addr` when `mem_cs`=0 is `fpc`. `mem_we` is always 0.

## Timing

- Reset values (asserted immediately, asynchronous): `mem_cs`=0, `mem_we`=0, `mem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=0, `instr_pc`=0; state `S_IDLE`, `fpc`=`RESET_PC`, count=0.
- Reset mid-operation drops all FIFO contents and any partial fetch.
- Cycles counted from the first rising edge after `rst_n` deasserts (edge 1 = `S_IDLE`):
  - `S_HI` in cycle 2, `S_LO` in cycle 3, `S_CAP` in cycle 4.
  - `instr_valid` is high from cycle 5.
- Sustained throughput: 1 instruction per 3 cycles.
- Redirect latency:
  - `instr_valid`=0 the cycle after `redirect`.
  - `mem_addr`=`redirect_pc` with `mem_cs`=1 the cycle after `redirect`.
  - The first redirected instruction is valid 3 cycles after that.
- `instr`, `instr_pc` and `instr_valid` are registered FIFO outputs and hold stable while `instr_valid && !instr_ready`.

## Structure

- `cpu_pkg` holds:
  - the `fetch_state_t` enum;
  - the `ADDR_W` and `INSTR_W`=16 constants;
  - the `fetch_entry_t` struct `{pc, instr}`.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t` with `DEPTH` entries.
  - Ports: push, pop, flush, count, head.
  - Wrap-around read/write pointers with an extra bit to distinguish full from empty.
- The top level holds the FSM, `fpc`, `hi_q` and the memory-port drive.

## Test plan

- Basic fetch: preload mem[0]=8'h12, mem[1]=8'h34, mem[2]=8'hAB, mem[3]=8'hCD; `instr_ready`=1.
  - Expect `instr`=16'h1234, `instr_pc`=0 in cycle 5.
  - Expect `instr`=16'hABCD, `instr_pc`=2 in cycle 8.
- Backpressure: `instr_ready`=0.
  - Expect two entries (pc 0 and 2), FSM in `S_FULL`, `mem_cs` held 0, `instr` stable at 16'h1234.
  - Then raise `instr_ready` -> pops in order, and the next `S_HI` fetches `mem_addr`=4.
- Redirect during `S_LO` with `redirect_pc`=16'h0101.
  - Expect FIFO empty the next cycle, then `mem_addr` 16'h0101 then 16'h0102.
  - Expect `instr_pc`=16'h0101 and no stale instruction emitted.
- Wrap: redirect to 16'hFFFF with mem[FFFF]=8'hAB, mem[0000]=8'hCD.
  - Expect `instr`=16'hABCD, `instr_pc`=16'hFFFF; the next fetch is at 16'h0001.
- Simultaneous events: count=1, push in `S_CAP` and pop in the same cycle -> count stays 1 and the new head is the pushed entry.
  - Also: redirect together with a pop -> the popped entry is consumed once and the FIFO is empty.
- Reset mid-operation: assert `rst_n`=0 with a full FIFO between clock edges.
  - Expect all outputs at reset values before the next edge.
  - After release, fetch restarts at `RESET_PC`.
